word_bank_scanner: RTL and testbench
====================================

WORD_BANK_SCANNER -- requirements
Module: word_bank_scanner

Interface
REQ-001 SHALL have parameter Width, default 8, giving the bits per word.
REQ-002 SHALL have parameter AddressSize, default 2, giving the slot index width; slot count N = 2**AddressSize.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port WrEn  input  1  write strobe for the word bank.
REQ-006 SHALL have port WrAddr  input  AddressSize  slot to write.
REQ-007 SHALL have port WrData  input  Width  word to write.
REQ-008 SHALL have port Start  input  1  request one scan of all N slots.
REQ-009 SHALL have port Abort  input  1  terminate the scan in progress.
REQ-010 SHALL have port Ready  input  1  downstream accepts the current beat.
REQ-011 SHALL have port D  output  Width*N  packed bank; slot i occupies bits [i*Width+Width-1 : i*Width].
REQ-012 SHALL have port S  output  AddressSize  current scan select, driven to the downstream word selector.
REQ-013 SHALL have port Valid  output  1  beat at slot S is presented.
REQ-014 SHALL have port Last  output  1  current beat is slot N-1.
REQ-015 SHALL have port Busy  output  1  FSM is not IDLE.
REQ-016 SHALL have port Done  output  1  one-cycle pulse at scan completion.

Function
REQ-017 SHALL hold N registered words; D SHALL be driven directly from these registers with no combinational path from any input.
REQ-018 SHALL write WrData into slot WrAddr at the clock edge when WrEn=1 and the FSM is IDLE.
REQ-019 SHALL ignore WrEn while in SCAN or DONE, leaving the bank unchanged.
REQ-020 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-021 IDLE->SCAN SHALL occur when Start=1 in IDLE; S SHALL be 0 on entry.
REQ-022 SHALL keep Valid=1 throughout SCAN and Valid=0 in IDLE and DONE.
REQ-023 SHALL hold S stable in SCAN while Ready=0 (no beat lost, no advance).
REQ-024 SHALL increment S by 1 when Valid=1 and Ready=1 and S<N-1.
REQ-025 SHALL go SCAN->DONE when Valid=1, Ready=1 and S=N-1.
REQ-026 SHALL set Last=1 exactly when Valid=1 and S=N-1.
REQ-027 SHALL stay in DONE for exactly one cycle with Done=1, then go DONE->IDLE; S SHALL return to 0 on entering IDLE.
REQ-028 SHALL ignore Start in SCAN and DONE; Start in IDLE SHALL be honoured only after DONE has completed (no back-to-back merge).
REQ-029 Abort=1 in SCAN SHALL move the FSM to IDLE at the next edge with S=0, without a Done pulse; Abort SHALL have priority over a completing handshake in the same cycle.
REQ-030 Abort SHALL be ignored in IDLE and DONE.
REQ-031 Simultaneous WrEn and Start in IDLE SHALL perform the write and start the scan at the same edge; the first beat SHALL see the new data on D.
REQ-032 Busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-033 With Ready held at 1, Start sampled at edge n SHALL give Valid at cycles n+1..n+N with S=0..N-1 and Done at cycle n+N+1.

Reset
REQ-034 Reset=0 SHALL immediately, independent of Clock, force the FSM to IDLE and set S=0, Valid=0, Last=0, Busy=0, Done=0 and all bank words to 0 (so D=0).
REQ-035 Reset asserted mid-scan SHALL abandon the scan with no Done pulse; after release the block SHALL be in IDLE.
REQ-036 Release of Reset SHALL be sampled synchronously; the first honoured Start or WrEn is at the first rising edge with Reset=1.

Verification (Width=8, AddressSize=2)
REQ-037 Write slots 0..3 = 0x11, 0x22, 0x33, 0x44 -> D=0x44332211.
REQ-038 Start with Ready=1 -> S=0,1,2,3 on 4 consecutive cycles with Valid=1; Last only at S=3; Done on the 5th cycle; Busy=0 after.
REQ-039 Ready=0 for 3 cycles at S=1 -> S stays 1 with Valid=1 for those cycles, then resumes; total 7 Valid cycles.
REQ-040 WrEn to slot 2 with 0xAA during SCAN -> D unchanged; the same write in IDLE with Start -> first-scan D[23:16]=0xAA.
REQ-041 Abort at S=3 with Ready=1 -> next cycle IDLE, S=0, no Done pulse.
REQ-042 Reset=0 at S=2 between clock edges -> Valid, Busy and D go to 0 immediately; Start after release runs a full 4-beat scan.

Source files
------------

// File: rtl/word_bank_scanner_if.sv
// word_bank_scanner_if
//   Bundles the write port, scan control and scan output of the word bank
//   scanner. Clock and reset are kept outside as plain ports.
//   master : driver side (writes words, starts/aborts scans, gives Ready)
//   slave  : scanner side (holds the bank, presents one beat per slot)
//   Signals:
//     WrEn/WrAddr/WrData : bank write strobe, slot index, word
//     Start/Abort        : begin a full scan / drop the scan in progress
//     Ready              : downstream accepts the beat at slot S
//     D                  : packed bank, slot i at [i*Width +: Width]
//     S/Valid/Last       : current beat select, beat present, final slot
//     Busy/Done          : scanner not idle, one-cycle completion pulse
interface word_bank_scanner_if #(
  parameter int Width       = 8,
  parameter int AddressSize = 2
);
  localparam int N = 2 ** AddressSize;

  logic                   WrEn;
  logic [AddressSize-1:0] WrAddr;
  logic [Width-1:0]       WrData;
  logic                   Start;
  logic                   Abort;
  logic                   Ready;
  logic [Width*N-1:0]     D;
  logic [AddressSize-1:0] S;
  logic                   Valid;
  logic                   Last;
  logic                   Busy;
  logic                   Done;

  modport master (
    output WrEn, WrAddr, WrData, Start, Abort, Ready,
    input  D, S, Valid, Last, Busy, Done
  );

  modport slave (
    input  WrEn, WrAddr, WrData, Start, Abort, Ready,
    output D, S, Valid, Last, Busy, Done
  );
endinterface

// File: rtl/word_bank_scanner.sv
// word_bank_scanner
//   Holds N = 2**AddressSize registered words and, on request, walks the
//   select S over every slot with a valid/ready handshake so a downstream
//   word selector can pick each word out of the packed bank D.
//   Ports:
//     Clock : rising-edge clock
//     Reset : asynchronous active-low reset (clears FSM and bank)
//     bus   : word_bank_scanner_if.slave (write port, scan control/outputs)
//   The bank is only writable while idle, so the words seen during a scan
//   cannot change under the downstream consumer.
module word_bank_scanner #(
  parameter int Width       = 8,
  parameter int AddressSize = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  word_bank_scanner_if.slave   bus
);

  localparam int N = 2 ** AddressSize;
  localparam logic [AddressSize-1:0] LastSlot = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [AddressSize-1:0] s_q, s_d;
  logic [Width-1:0]       bank_q [N];
  logic [Width-1:0]       bank_d [N];
  logic [Width*N-1:0]     d_flat;

  // ---------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        s_d = '0;
        if (bus.Start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Abort wins over a handshake landing in the same cycle.
        if (bus.Abort) begin
          state_d = IDLE;
          s_d     = '0;
        end else if (bus.Ready) begin
          if (s_q == LastSlot) begin
            state_d = DONE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Single completion cycle; Start/Abort seen here are dropped.
        state_d = IDLE;
        s_d     = '0;
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Word bank: one register per slot, written only in IDLE. A write that
  // coincides with Start lands at the same edge the scan begins, so the
  // first beat already sees it.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      always_comb begin
        bank_d[gi] = bank_q[gi];
        if (state_q == IDLE && bus.WrEn &&
            bus.WrAddr == AddressSize'(gi)) begin
          bank_d[gi] = bus.WrData;
        end
      end

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          bank_q[gi] <= '0;
        end else begin
          bank_q[gi] <= bank_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    d_flat = '0;
    for (int i = 0; i < N; i++) begin
      d_flat[i*Width +: Width] = bank_q[i];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all decoded from registers only.
  // ---------------------------------------------------------------------
  assign bus.D     = d_flat;
  assign bus.S     = s_q;
  assign bus.Valid = (state_q == SCAN);
  assign bus.Last  = (state_q == SCAN) && (s_q == LastSlot);
  assign bus.Busy  = (state_q != IDLE);
  assign bus.Done  = (state_q == DONE);

endmodule

// File: tb/tb_word_bank_scanner.sv
// tb_word_bank_scanner
//   Drives writes and scans into word_bank_scanner. The driver keeps a plain
//   array copy of the bank and, for every beat it expects the scanner to
//   hand over, pushes {slot, word, last} into a scoreboard queue. A monitor
//   on the falling edge pops an entry for every accepted beat and compares.
module tb_word_bank_scanner;
  localparam int W  = 8;
  localparam int AW = 2;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  word_bank_scanner_if #(.Width(W), .AddressSize(AW)) bus ();

  word_bank_scanner #(.Width(W), .AddressSize(AW)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         slot;
    logic [W-1:0] word;
    bit         last;
  } beat_t;

  beat_t          exp_q[$];
  logic [W-1:0]   mb [N];
  int             checks    = 0;
  int             errors    = 0;
  int             done_seen = 0;
  int             done_exp  = 0;
  beat_t          mon_e;
  logic [W*N-1:0] mon_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W*N-1:0] packed_model();
    logic [W*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = mb[i];
    return r;
  endfunction

  // Monitor: one comparison set per accepted beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.Valid && bus.Ready && !bus.Abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got beat at S=%0d expected none", bus.S);
        end else begin
          mon_e = exp_q.pop_front();
          mon_d = bus.D;
          chk("beat_S", 64'(bus.S), 64'(mon_e.slot));
          chk("beat_word", 64'(mon_d[bus.S*W +: W]), 64'(mon_e.word));
          chk("beat_last", 64'(bus.Last), 64'(mon_e.last));
          $display("beat S=%0d word=%02h last=%0b", bus.S, mon_d[bus.S*W +: W], bus.Last);
        end
      end
      if (bus.Done) done_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [W-1:0] d);
    bus.WrEn   = 1'b1;
    bus.WrAddr = AW'(a);
    bus.WrData = d;
    step();
    bus.WrEn = 1'b0;
    mb[a] = d;
    chk("bank_D", 64'(bus.D), 64'(packed_model()));
    $display("write slot=%0d data=%02h D=%08h", a, d, bus.D);
  endtask

  // mode 0: Ready always 1; mode 1: 3 stall cycles at S=1; mode 2: random Ready
  task automatic run_scan(input int mode, input int abort_at, input bit wr_start,
                          input int wr_a, input logic [W-1:0] wr_d);
    int b;
    int cyc;
    int stall;
    bit r;
    b = 0; cyc = 0; stall = 0;
    bus.Start = 1'b1;
    bus.Abort = 1'($urandom % 2);
    if (wr_start) begin
      bus.WrEn   = 1'b1;
      bus.WrAddr = AW'(wr_a);
      bus.WrData = wr_d;
      mb[wr_a]   = wr_d;
    end
    step();
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.WrEn  = 1'b0;
    while (b < N && cyc < 64) begin
      chk("scan_valid", 64'(bus.Valid), 64'(1));
      chk("scan_S", 64'(bus.S), 64'(b));
      chk("scan_busy", 64'(bus.Busy), 64'(1));
      // Stray writes during the scan must not reach the bank.
      bus.WrEn   = 1'($urandom % 2);
      bus.WrAddr = AW'($urandom);
      bus.WrData = W'($urandom);
      case (mode)
        0:       r = 1'b1;
        1:       r = !(b == 1 && stall < 3);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 1 && b == 1 && !r) stall++;
      cyc++;
      if (b == abort_at) begin
        bus.Abort = 1'b1;
        bus.Ready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
        step();
        bus.Abort = 1'b0;
        bus.Ready = 1'b0;
        bus.WrEn  = 1'b0;
        chk("abort_busy", 64'(bus.Busy), 64'(0));
        chk("abort_valid", 64'(bus.Valid), 64'(0));
        chk("abort_S", 64'(bus.S), 64'(0));
        chk("abort_done", 64'(bus.Done), 64'(0));
        $display("scan aborted at beat %0d", b);
        return;
      end
      bus.Ready = r;
      if (r) begin
        exp_q.push_back('{b, mb[b], (b == N-1)});
        b++;
      end
      step();
    end
    bus.Ready = 1'b0;
    bus.WrEn  = 1'b0;
    if (b < N) begin
      chk("scan_timeout", 64'(b), 64'(N));
      return;
    end
    if (mode == 0) chk("valid_cycles", 64'(cyc), 64'(N));
    if (mode == 1) chk("valid_cycles", 64'(cyc), 64'(N + 3));
    chk("done_pulse", 64'(bus.Done), 64'(1));
    chk("done_valid", 64'(bus.Valid), 64'(0));
    chk("done_busy", 64'(bus.Busy), 64'(1));
    chk("done_last", 64'(bus.Last), 64'(0));
    done_exp++;
    // Start, Abort and WrEn in DONE must all be dropped.
    bus.Start  = 1'b1;
    bus.Abort  = 1'b1;
    bus.WrEn   = 1'b1;
    bus.WrAddr = AW'($urandom);
    bus.WrData = W'($urandom);
    step();
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.WrEn  = 1'b0;
    chk("idle_busy", 64'(bus.Busy), 64'(0));
    chk("idle_valid", 64'(bus.Valid), 64'(0));
    chk("idle_S", 64'(bus.S), 64'(0));
    chk("idle_done", 64'(bus.Done), 64'(0));
    chk("idle_D", 64'(bus.D), 64'(packed_model()));
    $display("scan complete mode=%0d valid_cycles=%0d", mode, cyc);
  endtask

  initial begin
    bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrData = '0;
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.Ready = 1'b0;
    for (int i = 0; i < N; i++) mb[i] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.Valid), 64'(0));
    chk("rst_busy", 64'(bus.Busy), 64'(0));
    chk("rst_done", 64'(bus.Done), 64'(0));
    chk("rst_last", 64'(bus.Last), 64'(0));
    chk("rst_S", 64'(bus.S), 64'(0));
    chk("rst_D", 64'(bus.D), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    write_word(0, 8'h11);
    write_word(1, 8'h22);
    write_word(2, 8'h33);
    write_word(3, 8'h44);
    chk("bank_pattern", 64'(bus.D), 64'h44332211);

    run_scan(0, -1, 1'b0, 0, '0);
    run_scan(1, -1, 1'b0, 0, '0);
    run_scan(0, -1, 1'b1, 2, 8'hAA);
    run_scan(0, 3, 1'b0, 0, '0);

    // Asynchronous reset in the middle of a scan, between clock edges.
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    bus.Ready = 1'b1;
    exp_q.push_back('{0, mb[0], 1'b0});
    step();
    exp_q.push_back('{1, mb[1], 1'b0});
    step();
    bus.Ready = 1'b0;
    chk("pre_reset_S", 64'(bus.S), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.Valid), 64'(0));
    chk("mid_rst_busy", 64'(bus.Busy), 64'(0));
    chk("mid_rst_D", 64'(bus.D), 64'(0));
    chk("mid_rst_S", 64'(bus.S), 64'(0));
    chk("mid_rst_done", 64'(bus.Done), 64'(0));
    for (int i = 0; i < N; i++) mb[i] = '0;
    exp_q.delete();
    $display("reset applied mid-scan");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_scan(0, -1, 1'b0, 0, '0);

    for (int it = 0; it < 30; it++) begin
      if ($urandom % 3 == 0) begin
        write_word(int'($urandom % N), W'($urandom));
      end else begin
        run_scan(int'($urandom % 3),
                 ($urandom % 4 == 0) ? int'($urandom % N) : -1,
                 1'($urandom % 2), int'($urandom % N), W'($urandom));
      end
    end

    repeat (3) step();
    chk("done_count", 64'(done_seen), 64'(done_exp));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
